fetch_unit: RTL

Instruction fetch stage of the femtoRV32 core. It owns the program counter, issues one word-aligned read at a time to instruction memory and places the returned word into the IF/ID register. That register drives the decode stage (ImmGen, control, register file). It also handles decode back-pressure with a one-entry skid buffer and applies redirects from the branch-resolution stage.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time, fills the IF/ID
// register, absorbs decode back-pressure with a one-entry skid buffer and applies redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        misalign_err
);

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] skid_inst_r;
    logic [31:0] skid_inst_s;
    logic [31:0] skid_pc_r;
    logic [31:0] skid_pc_s;
    logic [31:0] inst_s;
    logic [31:0] inst_pc_s;
    logic        inst_valid_s;
    logic        misalign_s;
    logic        consume_s;

    // Request is decoded straight from the state so the first fetch leaves right after reset.
    assign imem_req  = (state_r == ST_ISSUE);
    assign imem_addr = word_align(pc_r);

    // Next-state and IF/ID/skid update logic; a redirect overrides every other action.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        skid_inst_s  = skid_inst_r;
        skid_pc_s    = skid_pc_r;
        inst_s       = inst;
        inst_pc_s    = inst_pc;
        inst_valid_s = inst_valid;
        consume_s    = inst_valid && !stall;
        misalign_s   = redirect && (redirect_pc[1:0] != 2'b00);

        if (redirect) begin
            pc_s         = word_align(redirect_pc);
            inst_valid_s = 1'b0;
            inst_s       = NOP_INST;
            // A response still in flight after this edge must be swallowed in DROP.
            case (state_r)
                ST_ISSUE: state_s = ST_DROP;
                ST_WAIT,
                ST_DROP:  state_s = imem_rvalid ? ST_ISSUE : ST_DROP;
                default:  state_s = ST_ISSUE;
            endcase
        end else begin
            if (consume_s) begin
                inst_valid_s = 1'b0;
            end else begin
                inst_valid_s = inst_valid;
            end

            case (state_r)
                ST_ISSUE: begin
                    state_s = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        pc_s = pc_r + 32'd4;
                        if (!inst_valid || !stall) begin
                            inst_s       = imem_rdata;
                            inst_pc_s    = pc_r;
                            inst_valid_s = 1'b1;
                            state_s      = ST_ISSUE;
                        end else begin
                            skid_inst_s = imem_rdata;
                            skid_pc_s   = pc_r;
                            state_s     = ST_SKID;
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_SKID: begin
                    if (!stall) begin
                        inst_s       = skid_inst_r;
                        inst_pc_s    = skid_pc_r;
                        inst_valid_s = 1'b1;
                        state_s      = ST_ISSUE;
                    end else begin
                        state_s = ST_SKID;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    state_s = ST_ISSUE;
                end
            endcase
        end
    end

    // State, PC, skid buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_ISSUE;
            pc_r         <= RESET_PC;
            skid_inst_r  <= 32'h0000_0000;
            skid_pc_r    <= 32'h0000_0000;
            inst         <= NOP_INST;
            inst_pc      <= 32'h0000_0000;
            inst_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            skid_inst_r  <= skid_inst_s;
            skid_pc_r    <= skid_pc_s;
            inst         <= inst_s;
            inst_pc      <= inst_pc_s;
            inst_valid   <= inst_valid_s;
            misalign_err <= misalign_s;
        end
    end

endmodule
